fetch_unit: RTL and testbench

- Instruction-fetch stage of the single-cycle core; sits directly upstream of instruct_mem and drives its Program_Count.
- Owns the PC register and issues sequential word addresses.
- Captures the one-cycle-latency Instruction response into a 2-entry output queue, and presents PC/instruction pairs to decode with a valid/ready handshake.
- Handles branch/jump redirects, and flags misaligned or out-of-range PCs.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruct_mem and buffers
// responses in a 2-entry FIFO toward decode. Optional FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core,
    output logic [31:0] Program_Count,
    input  logic [31:0] Instruction,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,
    input  logic        Decode_Ready,
    output logic        Fetch_Valid,
    output logic [31:0] Fetch_Instr,
    output logic [31:0] Fetch_PC,
    output logic        Fetch_Fault
);

    // Handshake: an entry moves to decode on a cycle where Fetch_Valid and Decode_Ready are
    // both high; the head is held stable while Fetch_Valid=1 and Decode_Ready=0.
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] MEM_WORDS = MEM_SIZE;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_fault_q, inflight_fault_d;
    logic        halt_q, halt_d;
    entry_t      ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]  count_q, count_d;

    entry_t      resp, head;
    logic        bypass, valid, pop, q_pop, push, issue, pc_fault;
    logic [2:0]  occ;

    assign pc_fault = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= MEM_WORDS);
    assign resp     = '{pc: inflight_pc_q,
                        instr: inflight_fault_q ? NOP : Instruction,
                        fault: inflight_fault_q};

`ifdef FETCH_BYPASS_EN
    assign bypass = (count_q == 2'd0) && inflight_q;
`else
    assign bypass = 1'b0;
`endif

    assign head  = bypass ? resp : ent0_q;
    assign valid = bypass || (count_q != 2'd0);
    assign pop   = valid && Decode_Ready;
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = !Rst_Core && !Redirect_Valid && !halt_q && (occ < 3'd2);
    // A bypassed response that decode takes immediately never enters the FIFO.
    assign push  = inflight_q && !Redirect_Valid && !(bypass && Decode_Ready);
    assign q_pop = pop && !bypass;

    assign Program_Count = pc_q;
    assign Fetch_Valid   = valid;
    assign Fetch_Instr   = valid ? head.instr : 32'h0;
    assign Fetch_PC      = valid ? head.pc : 32'h0;
    assign Fetch_Fault   = valid && head.fault;

    always_comb begin
        pc_d             = pc_q;
        inflight_d       = 1'b0;
        inflight_pc_d    = inflight_pc_q;
        inflight_fault_d = inflight_fault_q;
        halt_d           = halt_q;
        ent0_d           = ent0_q;
        ent1_d           = ent1_q;
        count_d          = count_q;

        if (issue) begin
            inflight_d       = 1'b1;
            inflight_pc_d    = pc_q;
            inflight_fault_d = pc_fault;
            pc_d             = pc_q + 32'd4;
            if (pc_fault) halt_d = 1'b1;
        end

        case ({push, q_pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = resp;
                else                 ent1_d = resp;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = resp;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = resp;
                end
            end
            default: ;
        endcase

        // Redirect squashes everything buffered or in flight, including a same-cycle pop.
        if (Redirect_Valid) begin
            pc_d       = Redirect_Target;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            halt_d     = 1'b0;
        end
    end

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            pc_q             <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= 32'h0;
            inflight_fault_q <= 1'b0;
            halt_q           <= 1'b0;
            ent0_q           <= '0;
            ent1_q           <= '0;
            count_q          <= 2'd0;
        end else begin
            pc_q             <= pc_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_fault_q <= inflight_fault_d;
            halt_q           <= halt_d;
            ent0_q           <= ent0_d;
            ent1_q           <= ent1_d;
            count_q          <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing sequences, a redirect vector table, and a
// random phase checked against an expected-stream model of the fetched program.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned MEM_SIZE = 1024;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_o;
    logic [31:0] instr = 32'h0;
    logic        redir = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        dec_rdy = 1'b1;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        f_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .MEM_SIZE(MEM_SIZE)) dut (
        .Clk_Core       (clk),
        .Rst_Core       (rst),
        .Program_Count  (pc_o),
        .Instruction    (instr),
        .Redirect_Valid (redir),
        .Redirect_Target(tgt),
        .Decode_Ready   (dec_rdy),
        .Fetch_Valid    (f_valid),
        .Fetch_Instr    (f_instr),
        .Fetch_PC       (f_pc),
        .Fetch_Fault    (f_fault)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MEM_SIZE];
    logic [64:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          accepts = 0;
    logic        armed = 1'b0;
    logic        hold_v = 1'b0;
    logic [64:0] hold_e = '0;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] pc1;
        logic [31:0] in1;
        logic        f1;
        logic        v2;
        logic [31:0] pc2;
        logic        f2;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a[31:12] == 20'h0) return mem[a[11:2]];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // The program as decode should see it from address t: sequential words until the first faulting address.
    task automatic refill(input logic [31:0] t);
        logic [31:0] p;
        logic        f;
        exp_q.delete();
        p = t;
        for (int i = 0; i < 2000; i++) begin
            f = (p[1:0] != 2'b00) || ((p >> 2) >= MEM_SIZE);
            exp_q.push_back({f, p, f ? NOP : rd(p)});
            if (f) break;
            p = p + 32'd4;
        end
    endtask

    task automatic monitor();
        logic [64:0] e;
        if (rst) begin
            refill(RESET_PC);
            armed = 1'b1;
            hold_v = 1'b0;
        end else if (armed) begin
            if (hold_v) chk("stall_hold", {f_valid, f_fault, f_pc, f_instr}, {1'b1, hold_e});
            if (redir) begin
                refill(tgt);
            end else if (f_valid && exp_q.size() == 0) begin
                chk("valid_while_halted", f_valid, 0);
            end else if (f_valid && dec_rdy) begin
                e = exp_q.pop_front();
                chk("stream", {f_fault, f_pc, f_instr}, e);
                accepts++;
            end
            hold_v = f_valid && !dec_rdy && !redir;
            hold_e = {f_fault, f_pc, f_instr};
        end
    endtask

    task automatic tick();
        logic [31:0] p;
        #1;
        monitor();
        p = pc_o;
        @(posedge clk);
        #1;
        instr = rd(p);
        #1;
    endtask

    task automatic expect_first(input string name, input logic [31:0] pc,
                                input logic [31:0] in, input logic flt);
        for (int i = 1; i < LAT; i++) begin
            tick();
            chk({name, "_gap"}, f_valid, 0);
        end
        tick();
        chk(name, {f_valid, f_fault, f_pc, f_instr}, {1'b1, flt, pc, in});
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 32'h1000_0000 + i;
        vecs[0] = '{32'h100,       32'h100,       32'h1000_0040, 1'b0, 1'b1, 32'h104,  1'b0};
        vecs[1] = '{32'h102,       32'h102,       NOP,           1'b1, 1'b0, 32'h0,    1'b0};
        vecs[2] = '{32'hFFC,       32'hFFC,       32'h1000_03FF, 1'b0, 1'b1, 32'h1000, 1'b1};
        vecs[3] = '{32'h1000,      32'h1000,      NOP,           1'b1, 1'b0, 32'h0,    1'b0};
        vecs[4] = '{32'h1,         32'h1,         NOP,           1'b1, 1'b0, 32'h0,    1'b0};
        vecs[5] = '{32'h0,         32'h0,         32'h1000_0000, 1'b0, 1'b1, 32'h4,    1'b0};
        vecs[6] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,           1'b1, 1'b0, 32'h0,    1'b0};
        vecs[7] = '{32'h200,       32'h200,       32'h1000_0080, 1'b0, 1'b1, 32'h204,  1'b0};

        // Reset values and first-fetch latency.
        tick();
        tick();
        chk("reset_outputs", {f_valid, f_fault, f_pc, f_instr}, 66'h0);
        chk("reset_pc", pc_o, RESET_PC);
        rst = 1'b0;
        expect_first("first_valid", 32'h0, 32'h1000_0000, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("stream_start", {f_valid, f_pc, f_instr}, {1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k)});
        end
        tick();

        // Stall with head at 0x10.
        dec_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk("stall_head", {f_valid, f_pc, f_instr}, {1'b1, 32'h10, 32'h1000_0004});
            tick();
        end
        chk("stall_pc_stop", pc_o, 32'h18);
        dec_rdy = 1'b1;
        for (int k = 4; k < 20; k++) begin
            chk("stall_resume", {f_valid, f_pc, f_instr}, {1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k)});
            tick();
        end

        // Redirect with the queue filled.
        dec_rdy = 1'b0;
        tick();
        tick();
        tick();
        redir = 1'b1;
        tgt = 32'h100;
        dec_rdy = 1'b1;
        tick();
        redir = 1'b0;
        chk("redir_full_gap", {f_valid, pc_o}, {1'b0, 32'h100});
        expect_first("redir_full_first", 32'h100, 32'h1000_0040, 1'b0);
        for (int k = 0; k < 4; k++) tick();

        // Redirect vector table.
        for (int v = 0; v < 8; v++) begin
            redir = 1'b1;
            tgt = vecs[v].tgt;
            tick();
            redir = 1'b0;
            chk("vec_gap", {f_valid, pc_o}, {1'b0, vecs[v].tgt});
            expect_first("vec_first", vecs[v].pc1, vecs[v].in1, vecs[v].f1);
            tick();
            chk("vec_second_valid", f_valid, vecs[v].v2);
            if (vecs[v].v2) chk("vec_second", {f_pc, f_fault}, {vecs[v].pc2, vecs[v].f2});
            tick();
            tick();
            tick();
            chk("vec_halt", f_valid, !(vecs[v].f1 || vecs[v].f2));
        end

        // Reset together with a redirect mid-stream.
        rst = 1'b1;
        redir = 1'b1;
        tgt = 32'h300;
        tick();
        rst = 1'b0;
        redir = 1'b0;
        chk("rst_redir_outputs", {f_valid, f_fault, f_pc, f_instr}, 66'h0);
        chk("rst_redir_pc", pc_o, RESET_PC);
        expect_first("rst_redir_first", RESET_PC, 32'h1000_0000, 1'b0);

        // Random phase.
        for (int c = 0; c < 3000; c++) begin
            dec_rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            redir = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 9))
                7:       tgt = 32'hFC0 + 32'(4 * $urandom_range(0, 15));
                8:       tgt = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
                9:       tgt = $urandom;
                default: tgt = 32'($urandom_range(0, 1023)) << 2;
            endcase
            tick();
        end
        rst = 1'b0;
        redir = 1'b0;
        tick();
        chk("random_progress", accepts > 500, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
